sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the extra clock cycles each SRAM half-access is held (0..7).
REQ-002 The block SHALL have parameter MEM_BASE, default 1024, meaning the byte address mapped to SRAM word 0.
REQ-003 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  in  1  asynchronous, active-low reset.
REQ-005 Port wr_en  in  1  MEM-stage store request.
REQ-006 Port rd_en  in  1  MEM-stage load request.
REQ-007 Port address  in  32  byte address, word-aligned.
REQ-008 Port write_data  in  32  store data.
REQ-009 Port read_data  out  32  load data toward the MEM/WB register, which supplies Result_WB.
REQ-010 Port ready  out  1  pipeline may advance; low freezes all pipeline registers.
REQ-011 Port SRAM_DQ  inout  16  external data bus.
REQ-012 Port SRAM_ADDR  out  18  external halfword address.
REQ-013 Ports SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes.

Function
REQ-014 The FSM SHALL have states IDLE, LOW, HIGH, DONE.
REQ-015 In IDLE with rd_en or wr_en high, the block SHALL latch address, write_data and operation, then go to LOW on the next edge.
REQ-016 When rd_en and wr_en are both high, the block SHALL perform a write.
REQ-017 LOW and HIGH SHALL each last exactly WAIT_CYCLES+1 cycles, timed by a wait counter that clears on every state entry.
REQ-018 After LOW the FSM SHALL go to HIGH, after HIGH to DONE, and after DONE to IDLE unconditionally.
REQ-019 word = (latched address - MEM_BASE) >> 2; SRAM_ADDR SHALL be {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH, truncated with no wrap check.
REQ-020 A read SHALL capture SRAM_DQ into read_data[15:0] on the last LOW cycle and into read_data[31:16] on the last HIGH cycle.
REQ-021 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT change read_data.
REQ-022 During write LOW/HIGH, the block SHALL drive SRAM_DQ with write_data[15:0]/[31:16] and hold SRAM_WE_N=0; at all other times SRAM_DQ SHALL be high-Z and SRAM_WE_N=1.
REQ-023 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N SHALL be 0 in LOW/HIGH and 1 otherwise; SRAM_OE_N SHALL be 0 only during read LOW/HIGH.
REQ-024 ready = ~(rd_en | wr_en) in IDLE, 0 in LOW/HIGH, 1 in DONE; ready SHALL be combinational from state and requests.
REQ-025 Total latency SHALL be 2*WAIT_CYCLES+3 edges from the IDLE cycle with a request to the DONE cycle.
REQ-026 Request or address changes after latching SHALL be ignored until IDLE.
REQ-027 A request held through DONE SHALL start a new access from the following IDLE cycle, so back-to-back accesses work.

Reset
REQ-028 When rst=0, the block SHALL immediately force state IDLE, counter 0, read_data 0, SRAM_DQ high-Z, all SRAM strobes 1 and SRAM_ADDR 0, including mid-access; the partial access SHALL be discarded.
REQ-029 ready SHALL follow REQ-024 from IDLE while in reset.

Structure
REQ-030 Package sram_pkg SHALL hold the state enum, MEM_BASE default, WAIT_CYCLES default, and widths 32/16/18.
REQ-031 The wait counter SHALL be a sub-module sram_wait_counter with ports clk, rst, clear, and done (count == WAIT_CYCLES).

Verification
REQ-032 WAIT_CYCLES=1: write addr 1028, data 0xDEADBEEF -> SRAM_ADDR 2 then 3, DQ 0xBEEF then 0xDEAD, WE_N=0 for 2 cycles each, ready=1 exactly 5 edges after the request.
REQ-033 Read addr 1028 with model returning 0xBEEF/0xDEAD -> read_data=0xDEADBEEF in DONE, held through a following write.
REQ-034 rd_en=wr_en=1 at addr 1024, data 0x12345678 -> write performed, OE_N stays 1, read_data unchanged.
REQ-035 Back-to-back: write then read held continuously -> second access starts the cycle after DONE, ready high exactly once per access.
REQ-036 rst=0 asserted in HIGH of a read -> immediate IDLE, DQ high-Z, strobes 1, read_data 0; next request completes normally.
REQ-037 WAIT_CYCLES=0 and 3 -> latency 3 and 9 edges, with read/write data correct.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types, widths and defaults for the 32-bit-over-16-bit SRAM controller.
package sram_pkg;
  localparam int unsigned DATA_W              = 32;
  localparam int unsigned DQ_W                = 16;
  localparam int unsigned SRAM_ADDR_W         = 18;
  localparam int unsigned CNT_W               = 3;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 1;
  localparam logic [31:0] DEFAULT_MEM_BASE    = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/sram_wait_counter.sv
// Counts cycles spent in one SRAM half-access; done once WAIT_CYCLES extra cycles have elapsed.
module sram_wait_counter
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stalled state never wraps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == LIMIT);
endmodule

// File: rtl/sram_controller.sv
// MEM-stage controller: splits each 32-bit load/store into a low and a high 16-bit SRAM access.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] MEM_BASE    = DEFAULT_MEM_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W-1:0]      address,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ready,
  inout  wire  [DQ_W-1:0]        SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [1:0]             state_dbg
);
  state_t            state, next_state;
  logic [DATA_W-1:0] addr_q, data_q, offset;
  logic              write_q, wait_done, clear, in_access, drive_dq;
  logic [DQ_W-1:0]   dq_out;
  logic              unused_offset_bits;

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .done  (wait_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Write wins when both requests are raised together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else if (state == IDLE && (rd_en || wr_en)) begin
      addr_q  <= address;
      data_q  <= write_data;
      write_q <= wr_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!write_q && wait_done) begin
      if (state == LOW)  read_data[15:0]  <= SRAM_DQ;
      if (state == HIGH) read_data[31:16] <= SRAM_DQ;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rd_en || wr_en) next_state = LOW;
      LOW:     if (wait_done)      next_state = HIGH;
      HIGH:    if (wait_done)      next_state = DONE;
      DONE:                        next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // The counter restarts on every state entry, so each half lasts WAIT_CYCLES+1 cycles.
  assign clear = (next_state != state) || (state == IDLE) || (state == DONE);

  // Handshake: ready is low from the IDLE cycle that carries a request until DONE,
  // where it is high for exactly one cycle; a request still high in DONE starts the next access.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = ~(rd_en | wr_en);
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign in_access = (state == LOW) || (state == HIGH);
  assign offset    = addr_q - MEM_BASE;
  assign SRAM_ADDR = in_access ? {offset[18:2], (state == HIGH)} : '0;
  assign SRAM_CE_N = ~in_access;
  assign SRAM_UB_N = ~in_access;
  assign SRAM_LB_N = ~in_access;
  assign SRAM_WE_N = ~(in_access & write_q);
  assign SRAM_OE_N = ~(in_access & ~write_q);

  assign drive_dq = in_access & write_q;
  assign dq_out   = (state == HIGH) ? data_q[31:16] : data_q[15:0];
  assign SRAM_DQ  = drive_dq ? dq_out : 'z;

  assign state_dbg          = state;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: three controllers (WAIT_CYCLES 0, 1, 3), each on its own 16-bit SRAM model.
`timescale 1ns/1ps
module tb_sram_controller;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wr_a[3], rd_a[3];
  logic [31:0] addr_a[3], wdata_a[3];
  wire  [31:0] rdata_a[3];
  wire         ready_a[3];
  wire  [17:0] saddr_a[3];
  wire  [4:0]  strb_a[3];   // {WE_N, CE_N, OE_N, UB_N, LB_N}
  wire  [1:0]  state_a[3];
  wire  [15:0] dq_mon[3];

  int checks = 0;
  int errors = 0;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    wire  [15:0] dq;
    logic [15:0] mem [0:255];
    logic        model_drive;

    assign model_drive = strb_a[i][4] && !strb_a[i][3] && !strb_a[i][2];
    assign dq          = model_drive ? mem[saddr_a[i][7:0]] : 16'bz;
    assign dq_mon[i]   = dq;

    always @(posedge clk) begin
      if (!strb_a[i][4] && !strb_a[i][3]) mem[saddr_a[i][7:0]] <= dq;
    end

    sram_controller #(.WAIT_CYCLES(wait_of(i)), .MEM_BASE(32'd1024)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_a[i]),
      .rd_en      (rd_a[i]),
      .address    (addr_a[i]),
      .write_data (wdata_a[i]),
      .read_data  (rdata_a[i]),
      .ready      (ready_a[i]),
      .SRAM_DQ    (dq),
      .SRAM_ADDR  (saddr_a[i]),
      .SRAM_WE_N  (strb_a[i][4]),
      .SRAM_CE_N  (strb_a[i][3]),
      .SRAM_OE_N  (strb_a[i][2]),
      .SRAM_UB_N  (strb_a[i][1]),
      .SRAM_LB_N  (strb_a[i][0]),
      .state_dbg  (state_a[i])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access on instance k, checking every cycle from the request to DONE.
  task automatic access(input int k, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input bit from_done, input bit hold);
    int          wc;
    logic [31:0] off;
    logic [16:0] word;
    logic        high;
    wc   = wait_of(k);
    off  = a - 32'd1024;
    word = off[18:2];
    wr_a[k] = w; rd_a[k] = r; addr_a[k] = a; wdata_a[k] = d;
    if (from_done) begin
      @(posedge clk); #1;
    end else begin
      #1;
    end
    check("idle_state", 32'(state_a[k]), 32'(IDLE));
    check("idle_ready", 32'(ready_a[k]), 32'd0);
    for (int n = 1; n <= 2 * wc + 2; n++) begin
      high = (n > wc + 1);
      @(posedge clk); #1;
      if (n == 1) begin
        wr_a[k] = r; rd_a[k] = w; addr_a[k] = ~a; wdata_a[k] = ~d;
      end
      check(high ? "high_state" : "low_state", 32'(state_a[k]), high ? 32'(HIGH) : 32'(LOW));
      check("busy_ready", 32'(ready_a[k]), 32'd0);
      check("sram_addr", 32'(saddr_a[k]), 32'({word, high}));
      check("strobes", 32'(strb_a[k]), w ? 32'b00100 : 32'b10000);
      if (w) check("dq_write", 32'(dq_mon[k]), high ? 32'(d[31:16]) : 32'(d[15:0]));
    end
    @(posedge clk); #1;
    check("done_state", 32'(state_a[k]), 32'(DONE));
    check("done_ready", 32'(ready_a[k]), 32'd1);
    check("done_strobes", 32'(strb_a[k]), 32'b11111);
    check("read_data", rdata_a[k], exp_rd);
    if (!hold) begin
      wr_a[k] = 1'b0; rd_a[k] = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      wr_a[k] = 1'b0; rd_a[k] = 1'b0; addr_a[k] = '0; wdata_a[k] = '0;
    end

    // Reset state, and ready following the request while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state_a[1]), 32'(IDLE));
    check("rst_ready", 32'(ready_a[1]), 32'd1);
    check("rst_read_data", rdata_a[1], 32'd0);
    check("rst_strobes", 32'(strb_a[1]), 32'b11111);
    check("rst_sram_addr", 32'(saddr_a[1]), 32'd0);
    rd_a[1] = 1'b1;
    #1;
    check("rst_ready_req", 32'(ready_a[1]), 32'd0);
    @(posedge clk); #1;
    check("rst_hold_idle", 32'(state_a[1]), 32'(IDLE));
    rd_a[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    access(1, 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1, 1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1, 1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 32'hDEADBEEF, 1'b0, 1'b0);
    access(1, 1'b0, 1'b1, 32'd1020, 32'h00000000, 32'h0BADC0DE, 1'b0, 1'b0);

    // Back-to-back: request held through DONE.
    access(1, 1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, 32'h0BADC0DE, 1'b0, 1'b1);
    access(1, 1'b0, 1'b1, 32'd1024, 32'h00000000, 32'h12345678, 1'b1, 1'b1);
    access(1, 1'b0, 1'b1, 32'd1032, 32'h00000000, 32'hCAFEF00D, 1'b1, 1'b0);

    // Reset asserted in the HIGH half of a read.
    rd_a[1] = 1'b1; addr_a[1] = 32'd1036;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_state", 32'(state_a[1]), 32'(HIGH));
    rst = 1'b0;
    #1;
    check("mid_rst_state", 32'(state_a[1]), 32'(IDLE));
    check("mid_rst_strobes", 32'(strb_a[1]), 32'b11111);
    check("mid_rst_sram_addr", 32'(saddr_a[1]), 32'd0);
    check("mid_rst_read_data", rdata_a[1], 32'd0);
    check("mid_rst_ready_req", 32'(ready_a[1]), 32'd0);
    rd_a[1] = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready_a[1]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 1'b1, 32'd1036, 32'h00000000, 32'hA5A55A5A, 1'b0, 1'b0);

    // Other wait settings: latency 3 and 9 edges.
    access(0, 1'b1, 1'b0, 32'd1040, 32'h01234567, 32'h00000000, 1'b0, 1'b0);
    access(0, 1'b0, 1'b1, 32'd1040, 32'h00000000, 32'h01234567, 1'b0, 1'b0);
    access(2, 1'b1, 1'b0, 32'd1100, 32'h89ABCDEF, 32'h00000000, 1'b0, 1'b0);
    access(2, 1'b0, 1'b1, 32'd1100, 32'h00000000, 32'h89ABCDEF, 1'b0, 1'b0);
    access(2, 1'b1, 1'b1, 32'd1100, 32'h13579BDF, 32'h89ABCDEF, 1'b0, 1'b0);
    access(2, 1'b0, 1'b1, 32'd1100, 32'h00000000, 32'h13579BDF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
